ps2_button_mapper: RTL and testbench

PS2_BUTTON_MAPPER -- requirements
Module: ps2_button_mapper

---
 rtl/ps2_button_mapper_if.sv | 20 ++
 rtl/ps2_button_mapper.sv | 144 ++++++++++++++
 tb/tb_ps2_button_mapper.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_button_mapper_if.sv
// Key-event and map-table write bus between the host logic and ps2_button_mapper.
interface ps2_button_mapper_if;
  logic [10:0] ps2_key;
  logic        map_wr;
  logic [4:0]  map_idx;
  logic [8:0]  map_code;
  logic        map_anyext;
  logic        map_valid;
  logic        key_hit;

  modport master (
    output ps2_key, map_wr, map_idx, map_code, map_anyext, map_valid,
    input  key_hit
  );

  modport slave (
    input  ps2_key, map_wr, map_idx, map_code, map_anyext, map_valid,
    output key_hit
  );
endinterface

// File: rtl/ps2_button_mapper.sv
// Maps PS/2 key events onto button channels, merges joystick inputs and
// applies per-button autofire or coin-pulse stretching.
module ps2_button_mapper #(
  parameter int unsigned N_BTN    = 16,
  parameter int unsigned AF_DIV   = 100000,
  parameter int unsigned COIN_MIN = 200000
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  ps2_button_mapper_if.slave   bus,
  input  logic [N_BTN-1:0]     joy,
  input  logic [N_BTN-1:0]     af_en,
  input  logic [N_BTN-1:0]     coin_mask,
  output logic [N_BTN-1:0]     btn_out
);

  localparam int unsigned AF_W   = $clog2(AF_DIV);
  localparam int unsigned COIN_W = $clog2(COIN_MIN + 1);
  localparam logic [AF_W-1:0]   AF_LAST   = AF_W'(AF_DIV - 1);
  // The rising-edge cycle itself counts toward the minimum pulse length.
  localparam logic [COIN_W-1:0] COIN_LOAD = COIN_W'(COIN_MIN - 1);

  typedef struct packed {
    logic       valid;
    logic       anyext;
    logic [8:0] code;
  } map_entry_t;

  map_entry_t         tbl_q [N_BTN];
  logic               armed_q;
  logic               tog_q;
  logic               key_hit_q;
  logic [N_BTN-1:0]   key_state_q;
  logic [N_BTN-1:0]   raw_q;
  logic [N_BTN-1:0]   stretch_q;
  logic [AF_W-1:0]    af_cnt_q;
  logic               af_phase_q;
  logic [COIN_W-1:0]  coin_cnt_q;

  logic               key_ev_c;
  logic [N_BTN-1:0]   match_c;
  logic [N_BTN-1:0]   raw_c;
  logic [N_BTN-1:0]   coin_rise_c;
  logic               coin_on_c;
  logic [N_BTN-1:0]   btn_d_c;

  assign bus.key_hit = key_hit_q;

  // Event detection and parallel table lookup against pre-write contents.
  always_comb begin
    key_ev_c = armed_q & (bus.ps2_key[10] ^ tog_q);
    match_c  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      match_c[i] = tbl_q[i].valid
                 & (bus.ps2_key[7:0] == tbl_q[i].code[7:0])
                 & (tbl_q[i].anyext | (bus.ps2_key[8] == tbl_q[i].code[8]));
    end
  end

  // armed_q keeps the first post-reset sample of the toggle bit from firing.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      armed_q <= 1'b0;
      tog_q   <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      tog_q   <= bus.ps2_key[10];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_BTN; i++) tbl_q[i] <= '0;
    end else if (bus.map_wr) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (bus.map_idx == 5'(i)) begin
          tbl_q[i] <= '{valid: bus.map_valid, anyext: bus.map_anyext, code: bus.map_code};
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      key_state_q <= '0;
      key_hit_q   <= 1'b0;
    end else begin
      key_hit_q <= key_ev_c & (|match_c);
      if (key_ev_c) begin
        key_state_q <= (key_state_q & ~match_c) | (match_c & {N_BTN{bus.ps2_key[9]}});
      end
    end
  end

  assign raw_c       = key_state_q | joy;
  assign coin_rise_c = raw_c & ~raw_q & coin_mask;
  assign coin_on_c   = (coin_cnt_q != '0);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt_q   <= '0;
      af_phase_q <= 1'b1;
    end else if (af_cnt_q == AF_LAST) begin
      af_cnt_q   <= '0;
      af_phase_q <= ~af_phase_q;
    end else begin
      af_cnt_q <= af_cnt_q + AF_W'(1);
    end
  end

  // Shared coin timer: a new rising edge always reloads and adds its bit.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      raw_q      <= '0;
      stretch_q  <= '0;
      coin_cnt_q <= '0;
    end else begin
      raw_q <= raw_c;
      if (|coin_rise_c) begin
        coin_cnt_q <= COIN_LOAD;
        stretch_q  <= stretch_q | coin_rise_c;
      end else if (coin_on_c) begin
        coin_cnt_q <= coin_cnt_q - COIN_W'(1);
      end else begin
        stretch_q <= '0;
      end
    end
  end

  always_comb begin
    btn_d_c = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (coin_mask[i])  btn_d_c[i] = raw_c[i] | (stretch_q[i] & coin_on_c);
      else if (af_en[i]) btn_d_c[i] = raw_c[i] & af_phase_q;
      else               btn_d_c[i] = raw_c[i];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) btn_out <= '0;
    else          btn_out <= btn_d_c;
  end

endmodule

// File: tb/tb_ps2_button_mapper.sv
// Directed bench for ps2_button_mapper with a cycle-level behavioural model
// compared on every falling edge.
module tb_ps2_button_mapper;
  localparam int unsigned NB   = 8;
  localparam int unsigned AFD  = 4;
  localparam int unsigned CMIN = 10;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b1;
  logic [NB-1:0] joy = '0;
  logic [NB-1:0] af_en = '0;
  logic [NB-1:0] coin_mask = '0;
  logic [NB-1:0] btn_out;
  bit            started = 1'b0;

  ps2_button_mapper_if bus();

  ps2_button_mapper #(.N_BTN(NB), .AF_DIV(AFD), .COIN_MIN(CMIN)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .bus       (bus),
    .joy       (joy),
    .af_en     (af_en),
    .coin_mask (coin_mask),
    .btn_out   (btn_out)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Model state: table, pressed keys, cycle index since reset release,
  // timestamp of last coin rising edge.
  bit [8:0]  t_code [NB];
  bit        t_any  [NB];
  bit        t_val  [NB];
  bit [NB-1:0] mks, mprev_raw, mstr, m_raw, m_rise, m_nb;
  bit        prev10, m_ev, m_hit, m_phase;
  int        k, last_rise;
  bit [NB-1:0] exp_btn;
  bit        exp_hit;

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NB; i++) begin t_code[i] = '0; t_any[i] = 0; t_val[i] = 0; end
      mks = '0; mstr = '0; mprev_raw = '0; prev10 = 0;
      k = 0; last_rise = 0; exp_btn = '0; exp_hit = 0;
    end else begin
      m_raw   = mks | joy;
      m_rise  = m_raw & ~mprev_raw & coin_mask;
      m_phase = ((k / int'(AFD)) % 2) == 0;
      for (int i = 0; i < NB; i++) begin
        if (coin_mask[i])
          m_nb[i] = m_raw[i] | (mstr[i] && (k > last_rise) && (k - last_rise < int'(CMIN)));
        else if (af_en[i])
          m_nb[i] = m_raw[i] & m_phase;
        else
          m_nb[i] = m_raw[i];
      end
      exp_btn = m_nb;
      if (m_rise != 0) begin
        last_rise = k;
        mstr = mstr | m_rise;
      end else if (k - last_rise >= int'(CMIN)) begin
        mstr = '0;
      end
      mprev_raw = m_raw;
      m_ev   = (k >= 1) && (bus.ps2_key[10] != prev10);
      prev10 = bus.ps2_key[10];
      m_hit  = 0;
      if (m_ev) begin
        for (int i = 0; i < NB; i++) begin
          if (t_val[i] && bus.ps2_key[7:0] == t_code[i][7:0] &&
              (t_any[i] || bus.ps2_key[8] == t_code[i][8])) begin
            mks[i] = bus.ps2_key[9];
            m_hit  = 1;
          end
        end
      end
      exp_hit = m_hit;
      if (bus.map_wr && bus.map_idx < NB) begin
        t_code[bus.map_idx] = bus.map_code;
        t_any[bus.map_idx]  = bus.map_anyext;
        t_val[bus.map_idx]  = bus.map_valid;
      end
      k++;
    end
  end

  always @(negedge clk_sys) begin
    if (started) begin
      chk("model_btn_out", 32'(btn_out), 32'(exp_btn));
      chk("model_key_hit", 32'(bus.key_hit), 32'(exp_hit));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic map_write(input logic [4:0] idx, input logic [8:0] code,
                           input logic ax, input logic v);
    bus.map_idx = idx; bus.map_code = code; bus.map_anyext = ax; bus.map_valid = v;
    bus.map_wr = 1'b1;
    tick(1);
    bus.map_wr = 1'b0;
  endtask

  task automatic key_ev(input logic p, input logic [8:0] code);
    bus.ps2_key = {~bus.ps2_key[10], p, code};
  endtask

  task automatic coin_run(input int p2, output int highs, output int last);
    highs = 0;
    last  = -1;
    for (int j = 0; j < 30; j++) begin
      joy[3] = (j == 0) || (j == p2);
      tick(1);
      if (btn_out[3]) begin highs++; last = j; end
    end
    joy[3] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit s [20];
    int tr [$];
    int bad_diff, highs, last;

    bus.ps2_key = 11'h400;
    bus.map_wr = 0; bus.map_idx = '0; bus.map_code = '0;
    bus.map_anyext = 0; bus.map_valid = 0;
    #2 reset_n = 1'b0;
    #1 started = 1'b1;
    tick(3);
    chk("rst_btn_out", 32'(btn_out), 0);
    chk("rst_key_hit", 32'(bus.key_hit), 0);
    reset_n = 1'b1;
    tick(5);
    chk("no_evt_after_rst_hit", 32'(bus.key_hit), 0);
    chk("no_evt_after_rst_btn", 32'(btn_out), 0);

    // anyext entry hit by extended code, two-cycle latency
    map_write(5'd2, 9'h075, 1'b1, 1'b1);
    key_ev(1'b1, 9'h175);
    tick(1);
    chk("press_hit_pulse", 32'(bus.key_hit), 1);
    chk("press_btn_not_yet", 32'(btn_out[2]), 0);
    tick(1);
    chk("press_hit_drop", 32'(bus.key_hit), 0);
    chk("press_btn2", 32'(btn_out[2]), 1);
    key_ev(1'b0, 9'h175);
    tick(2);
    chk("release_btn2", 32'(btn_out[2]), 0);

    // two entries share a code; mismatches and out-of-range writes
    map_write(5'd0, 9'h014, 1'b0, 1'b1);
    map_write(5'd5, 9'h014, 1'b0, 1'b1);
    key_ev(1'b1, 9'h014);
    tick(2);
    chk("dual_match_btn", 32'(btn_out), 32'h21);
    key_ev(1'b1, 9'h015);
    tick(1);
    chk("code_miss_hit", 32'(bus.key_hit), 0);
    key_ev(1'b1, 9'h114);
    tick(1);
    chk("ext_miss_hit", 32'(bus.key_hit), 0);
    map_write(5'd9, 9'h033, 1'b1, 1'b1);
    key_ev(1'b1, 9'h033);
    tick(1);
    chk("idx_oor_ignored", 32'(bus.key_hit), 0);
    key_ev(1'b0, 9'h014);
    tick(2);
    chk("dual_release_btn", 32'(btn_out), 0);

    // autofire on button 1
    af_en = 8'h02;
    joy   = 8'h02;
    for (int j = 0; j < 20; j++) begin
      tick(1);
      s[j] = btn_out[1];
    end
    for (int j = 1; j < 20; j++) if (s[j] != s[j-1]) tr.push_back(j);
    bad_diff = 0;
    for (int j = 1; j < tr.size(); j++) if (tr[j] - tr[j-1] != 4) bad_diff++;
    chk("af_toggle_count_ge4", 32'(tr.size() >= 4), 1);
    chk("af_period_4", 32'(bad_diff), 0);
    joy = '0;
    tick(1);
    chk("af_drop", 32'(btn_out[1]), 0);
    af_en = '0;
    tick(2);

    // coin stretch on button 3 (autofire enable must be ignored)
    coin_mask = 8'h08;
    af_en     = 8'h08;
    coin_run(-1, highs, last);
    chk("coin_single_len", 32'(highs), 10);
    chk("coin_single_last", 32'(last), 9);
    coin_run(5, highs, last);
    chk("coin_restart_len", 32'(highs), 15);
    chk("coin_restart_last", 32'(last), 14);
    coin_run(9, highs, last);
    chk("coin_expire_rise_len", 32'(highs), 19);
    chk("coin_expire_rise_last", 32'(last), 18);

    // reset mid-stretch, toggle during reset
    joy[3] = 1'b1;
    tick(1);
    joy[3] = 1'b0;
    tick(3);
    chk("stretch_active", 32'(btn_out[3]), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_stretch", 32'(btn_out), 0);
    key_ev(1'b1, 9'h175);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("rst_toggle_no_hit", 32'(bus.key_hit), 0);
    key_ev(1'b1, 9'h175);
    tick(1);
    chk("table_cleared_hit", 32'(bus.key_hit), 0);
    tick(1);
    chk("table_cleared_btn", 32'(btn_out), 0);
    coin_mask = '0;
    af_en     = '0;

    // write and matching event in the same cycle
    bus.map_idx = 5'd4; bus.map_code = 9'h020; bus.map_anyext = 0; bus.map_valid = 1;
    bus.map_wr  = 1'b1;
    key_ev(1'b1, 9'h020);
    tick(1);
    bus.map_wr = 1'b0;
    chk("wr_same_cycle_hit", 32'(bus.key_hit), 0);
    tick(1);
    chk("wr_same_cycle_btn", 32'(btn_out[4]), 0);
    key_ev(1'b1, 9'h020);
    tick(1);
    chk("wr_next_hit", 32'(bus.key_hit), 1);
    tick(1);
    chk("wr_next_btn", 32'(btn_out[4]), 1);

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
